packet_tx: RTL
==============

PACKET_TX -- requirements
Module: packet_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, router byte width.
REQ-002 The block SHALL have parameter DATA_SIZE, default 6, payload length field width; DATA_WIDTH == DATA_SIZE+2 is required.
REQ-003 The block SHALL have one clock and asynchronous active-low reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 cmd_valid  input  1  packet command offered.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid&cmd_ready at a clock edge.
REQ-008 cmd_addr  input  2  destination address, header bits [1:0].
REQ-009 cmd_len  input  DATA_SIZE  payload byte count, 0..2^DATA_SIZE-1, header bits [DATA_WIDTH-1:2].
REQ-010 crc_en  input  1  append check byte; sampled only at command accept.
REQ-011 pl_data  input  DATA_WIDTH  payload byte.
REQ-012 pl_valid  input  1  payload byte offered.
REQ-013 pl_ready  output  1  payload byte taken when pl_valid&pl_ready at a clock edge.
REQ-014 data_out  output  DATA_WIDTH  byte to router input, registered.
REQ-015 data_out_req  output  1  data_out valid, registered; drives router data_in_req.
REQ-016 data_out_ack  input  1  router accepts data_out this cycle.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse after the last byte of a packet is acked.

Function
REQ-019 The link SHALL transfer a byte on each rising edge where data_out_req=1 and data_out_ack=1; data_out SHALL hold stable while data_out_req=1 and data_out_ack=0.
REQ-020 States SHALL be IDLE, PLD, CHK, DRAIN; cmd_ready=1 only in IDLE.
REQ-021 On command accept: data_out<={cmd_len,cmd_addr}, data_out_req<=1, checksum<=header, remaining<=cmd_len, crc_en latched; next state PLD if cmd_len>0, else CHK if crc_en, else DRAIN.
REQ-022 Output slot SHALL be free when data_out_req=0 or data_out_ack=1 (combinational on data_out_ack).
REQ-023 pl_ready SHALL equal (state==PLD) and slot free.
REQ-024 In PLD on pl_valid&pl_ready: data_out<=pl_data, data_out_req<=1, checksum^=pl_data, remaining-=1; at remaining 1->0 go to CHK if latched crc_en else DRAIN.
REQ-025 In PLD when slot freed by ack with no payload load, data_out_req<=0 (bubble); no byte SHALL be duplicated or dropped.
REQ-026 In CHK when slot free: data_out<=checksum (XOR of header and all payload bytes), data_out_req<=1, go to DRAIN.
REQ-027 In DRAIN on data_out_ack: data_out_req<=0, done<=1 for one cycle, go to IDLE.
REQ-028 With ack held high and pl_valid held high, payload SHALL stream at one byte per cycle; header-to-payload and payload-to-check SHALL have no bubble.
REQ-029 cmd_valid outside IDLE SHALL be ignored; inputs SHALL not be checked for X.
REQ-030 Minimum gap between packets SHALL be one cycle (DRAIN ack edge -> IDLE accept edge).

Reset
REQ-031 While rst_n=0: state IDLE, data_out=0, data_out_req=0, done=0, busy=0, cmd_ready=1 after release, pl_ready=0, checksum=0, remaining=0.
REQ-032 Reset mid-packet SHALL drop data_out_req immediately (asynchronously); the partial packet is abandoned, not resumed.

Verification
REQ-033 addr=2, len=3, crc_en=1, payload 0x01,0x02,0x04, ack always 1 -> data_out 0x0E,0x01,0x02,0x04,0x09 on 5 consecutive req cycles, then done pulse.
REQ-034 Same packet, crc_en=0 -> bytes 0x0E,0x01,0x02,0x04 only; done one cycle after 0x04 acked.
REQ-035 len=0, addr=1, crc_en=1 -> bytes 0x01,0x01; len=0, crc_en=0 -> single byte 0x01.
REQ-036 ack toggling 1-0-1-0 with random pl_valid gaps -> byte sequence and checksum unchanged, data_out stable while req&!ack, pl_ready never high when slot occupied.
REQ-037 len=63, addr=3, payload 0x00..0x3E -> header 0xFF, 63 payload bytes, check byte = 0xFF ^ XOR(0x00..0x3E) = 0xC0; remaining reaches 0 without wrap.
REQ-038 rst_n low after second payload byte -> data_out_req=0 same cycle, busy=0; next command after release sends fresh header.

Source files
------------

// File: rtl/packet_tx_if.sv
// Command, payload and router-output signals of the packet transmitter.
//
// Handshakes: a transfer happens on a rising clk edge where the
// valid-side signal (cmd_valid, pl_valid, data_out_req) and the
// ready-side signal (cmd_ready, pl_ready, data_out_ack) are both 1.
// The offering side keeps its data stable until that edge.
interface packet_tx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_SIZE  = 6
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_addr;
    logic [DATA_SIZE-1:0]  cmd_len;
    logic                  crc_en;
    logic [DATA_WIDTH-1:0] pl_data;
    logic                  pl_valid;
    logic                  pl_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_req;
    logic                  data_out_ack;

    // Environment side: issues commands and payload, acks the router link.
    modport master (
        output cmd_valid, cmd_addr, cmd_len, crc_en, pl_data, pl_valid, data_out_ack,
        input  cmd_ready, pl_ready, data_out, data_out_req
    );

    // Transmitter side.
    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, crc_en, pl_data, pl_valid, data_out_ack,
        output cmd_ready, pl_ready, data_out, data_out_req
    );
endinterface

// File: rtl/packet_tx.sv
// Packet transmitter: sends a header byte {len, addr}, len payload bytes
// and an optional XOR check byte over a req/ack byte link to a router.
// The single output register doubles as the link buffer; a new byte may
// be loaded in the same cycle the previous one is acked.
module packet_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_SIZE  = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    packet_tx_if.slave bus,
    output logic       busy,
    output logic       done,
    output logic [1:0] dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLD   = 2'd1,
        CHK   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  req_q, req_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] chk_q, chk_d;
    logic [DATA_SIZE-1:0]  rem_q, rem_d;
    logic                  crc_q, crc_d;

    logic slot_free;
    logic pl_take;

    // The output register can take a new byte if it is empty or being acked now.
    assign slot_free = !req_q || bus.data_out_ack;
    assign pl_take   = (state_q == PLD) && slot_free && bus.pl_valid;

    assign bus.cmd_ready    = (state_q == IDLE);
    assign bus.pl_ready     = (state_q == PLD) && slot_free;
    assign bus.data_out     = data_q;
    assign bus.data_out_req = req_q;
    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign dbg_state_o      = state_q;

    // State and datapath registers; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            chk_q   <= '0;
            rem_q   <= '0;
            crc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            req_q   <= req_d;
            done_q  <= done_d;
            chk_q   <= chk_d;
            rem_q   <= rem_d;
            crc_q   <= crc_d;
        end
    end

    // Next-state and output-register loading for each packet phase.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        req_d   = req_q;
        done_d  = 1'b0;
        chk_d   = chk_q;
        rem_d   = rem_q;
        crc_d   = crc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    data_d = {bus.cmd_len, bus.cmd_addr};
                    req_d  = 1'b1;
                    chk_d  = {bus.cmd_len, bus.cmd_addr};
                    rem_d  = bus.cmd_len;
                    crc_d  = bus.crc_en;
                    if (bus.cmd_len != '0) begin
                        state_d = PLD;
                    end else if (bus.crc_en) begin
                        state_d = CHK;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            PLD: begin
                if (pl_take) begin
                    data_d = bus.pl_data;
                    req_d  = 1'b1;
                    chk_d  = chk_q ^ bus.pl_data;
                    rem_d  = rem_q - ONE;
                    if (rem_q == ONE) begin
                        state_d = crc_q ? CHK : DRAIN;
                    end
                end else if (slot_free) begin
                    // Byte acked but no payload ready: leave a bubble.
                    req_d = 1'b0;
                end
            end
            CHK: begin
                if (slot_free) begin
                    data_d  = chk_q;
                    req_d   = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (req_q && bus.data_out_ack) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
